// File: rtl/ex_integrate_dump.sv
`default_nettype none
// ============================================================================
// ex_integrate_dump : signed integrate-and-dump decimator, rounding + saturation
// Revision: 1.0
// ============================================================================
module ex_integrate_dump #(
    parameter  int DATA_WIDTH = 32,
    parameter  int DEC_MAX    = 16,
    parameter  int OUT_SHIFT  = 4,
    localparam int CNT_W      = $clog2(DEC_MAX + 1),
    localparam int ACC_W      = DATA_WIDTH + $clog2(DEC_MAX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  ce,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0]      dec_len,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  sat_flag
);

    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [SUM_W-1:0] OUT_MAX =
        {{(SUM_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_W-1:0] OUT_MIN =
        {{(SUM_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    logic signed [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [CNT_W-1:0]             len_q, len_d;
    logic                         load_q;
    logic [DATA_WIDTH-1:0]        data_out_q, data_out_d;
    logic                         valid_q, valid_d;
    logic                         sat_q, sat_d;

    logic [CNT_W-1:0]             len_clamp;
    logic [CNT_W-1:0]             len_eff;
    logic                         last;
    logic signed [ACC_W-1:0]      sample_ext;
    logic signed [SUM_W-1:0]      sum;
    logic signed [SUM_W-1:0]      scaled;
    logic [DATA_WIDTH-1:0]        result;
    logic                         sat_hit;

    assign len_clamp = (dec_len == '0)                    ? CNT_W'(1) :
                       (dec_len > CNT_W'(DEC_MAX))         ? CNT_W'(DEC_MAX) :
                                                             dec_len;

    // Right after reset release the window length comes straight from dec_len.
    assign len_eff    = load_q ? len_clamp : len_q;
    assign last       = (cnt_q == len_eff - CNT_W'(1));
    assign sample_ext = {{(ACC_W - DATA_WIDTH){data_in[DATA_WIDTH-1]}}, data_in};
    assign sum        = {acc_q[ACC_W-1], acc_q} + {sample_ext[ACC_W-1], sample_ext};

    generate
        if (OUT_SHIFT > 0) begin : g_round
            localparam logic signed [SUM_W-1:0] RND = SUM_W'(1) << (OUT_SHIFT - 1);
            logic signed [SUM_W-1:0] biased;
            assign biased = sum + RND;
            assign scaled = biased >>> OUT_SHIFT;
        end else begin : g_no_round
            assign scaled = sum;
        end
    endgenerate

    always_comb begin
        sat_hit = 1'b0;
        result  = scaled[DATA_WIDTH-1:0];
        if (scaled > OUT_MAX) begin
            sat_hit = 1'b1;
            result  = OUT_MAX[DATA_WIDTH-1:0];
        end else if (scaled < OUT_MIN) begin
            sat_hit = 1'b1;
            result  = OUT_MIN[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_eff;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        sat_d      = sat_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
            len_d = len_clamp;
            sat_d = 1'b0;
        end else if (ce) begin
            if (last) begin
                acc_d      = '0;
                cnt_d      = '0;
                len_d      = len_clamp;
                data_out_d = result;
                valid_d    = 1'b1;
                if (sat_hit) begin
                    sat_d = 1'b1;
                end
            end else begin
                acc_d = acc_q + sample_ext;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= CNT_W'(1);
            load_q     <= 1'b1;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            load_q     <= 1'b0;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            sat_q      <= sat_d;
        end
    end

    assign data_valid = valid_q;
    assign data_out   = data_out_q;
    assign sat_flag   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_integrate_dump.sv
`default_nettype none
// ============================================================================
// tb_ex_integrate_dump : directed bench over three parameterisations
// Revision: 1.0
// ============================================================================
module tb_ex_integrate_dump;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, ce;
    logic [15:0] din;
    logic [3:0]  dec_len;

    logic        v0, v2, v8, s0, s2, s8;
    logic [15:0] o0, o2;
    logic [7:0]  o8;

    int errors = 0;
    int checks = 0;

    ex_integrate_dump #(.DATA_WIDTH(16), .DEC_MAX(8), .OUT_SHIFT(0)) u_s0 (
        .clk(clk), .rst(rst), .clr(clr), .ce(ce), .data_in(din), .dec_len(dec_len),
        .data_valid(v0), .data_out(o0), .sat_flag(s0));

    ex_integrate_dump #(.DATA_WIDTH(16), .DEC_MAX(8), .OUT_SHIFT(2)) u_s2 (
        .clk(clk), .rst(rst), .clr(clr), .ce(ce), .data_in(din), .dec_len(dec_len),
        .data_valid(v2), .data_out(o2), .sat_flag(s2));

    ex_integrate_dump #(.DATA_WIDTH(8), .DEC_MAX(8), .OUT_SHIFT(0)) u_w8 (
        .clk(clk), .rst(rst), .clr(clr), .ce(ce), .data_in(din[7:0]), .dec_len(dec_len),
        .data_valid(v8), .data_out(o8), .sat_flag(s8));

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic c, input logic signed [15:0] d);
        ce  = c;
        din = d;
        @(posedge clk);
        #1;
        ce  = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; ce = 1'b0; din = '0; dec_len = 4'd4;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out",   $signed(o0), 0);
        chk("reset_valid", v0, 0);
        chk("reset_sat",   s8, 0);
        rst = 1'b1;

        // basic sum
        cyc(1, 1); cyc(1, 2); cyc(1, 3);
        chk("basic_early", v0, 0);
        cyc(1, 4);
        chk("basic_valid", v0, 1);
        chk("basic_out",   $signed(o0), 10);
        chk("basic_sat",   s0, 0);
        chk("basic_sh2",   $signed(o2), 3);
        cyc(0, 0);
        chk("basic_pulse", v0, 0);
        chk("basic_hold",  $signed(o0), 10);

        // rounding
        cyc(1, 1); cyc(1, 1); cyc(1, 1); cyc(1, 1);
        chk("rnd_ones_v", v2, 1);
        chk("rnd_ones",   $signed(o2), 1);
        cyc(1, -1); cyc(1, -1); cyc(1, 0); cyc(1, 0);
        chk("rnd_half",   $signed(o2), 0);
        cyc(1, -3); cyc(1, 0); cyc(1, 0); cyc(1, 0);
        chk("rnd_neg",    $signed(o2), -1);

        // saturation
        repeat (4) cyc(1, 127);
        chk("sat_pos",     $signed(o8), 127);
        chk("sat_pos_f",   s8, 1);
        chk("sat_wide",    $signed(o0), 508);
        chk("sat_wide_f",  s0, 0);
        repeat (4) cyc(1, -128);
        chk("sat_neg",     $signed(o8), -128);
        chk("sat_neg_f",   s8, 1);
        chk("sat_neg_wide", $signed(o0), -512);
        clr = 1'b1;
        cyc(0, 0);
        chk("clr_sat",     s8, 0);
        chk("clr_hold",    $signed(o8), -128);
        chk("clr_valid",   v8, 0);

        // length edges
        dec_len = 4'd0;
        clr = 1'b1;
        cyc(0, 0);
        cyc(1, 5);
        chk("len0_v",    v0, 1);
        chk("len0_out",  $signed(o0), 5);
        chk("len0_sh2",  $signed(o2), 1);
        cyc(1, -7);
        chk("len0_b2b",  v0, 1);
        chk("len0_out2", $signed(o0), -7);
        chk("len0_sh2b", $signed(o2), -2);
        dec_len = 4'd1;
        cyc(1, 9);
        chk("len1_out",  $signed(o0), 9);
        dec_len = 4'd13;
        cyc(1, 0);
        chk("len1_last", v0, 1);
        chk("len1_zero", $signed(o0), 0);
        repeat (7) cyc(1, 1);
        chk("lenmax_early", v0, 0);
        dec_len = 4'd4;
        cyc(1, 1);
        chk("lenmax_v",   v0, 1);
        chk("lenmax_out", $signed(o0), 8);
        cyc(1, 1); cyc(1, 2);
        dec_len = 4'd2;
        cyc(1, 3);
        chk("chg_early", v0, 0);
        cyc(1, 4);
        chk("chg_v4",    v0, 1);
        chk("chg_out4",  $signed(o0), 10);
        cyc(1, 5);
        chk("chg_early2", v0, 0);
        dec_len = 4'd3;
        cyc(1, 6);
        chk("chg_out2",  $signed(o0), 11);

        // gaps
        cyc(1, 5); cyc(1, 6);
        cyc(0, 0); cyc(0, 0); cyc(0, 0);
        chk("gap_early", v0, 0);
        cyc(1, 7);
        chk("gap_out",   $signed(o0), 18);
        chk("gap_sh2",   $signed(o2), 5);

        // abort
        cyc(1, 10); cyc(1, 20);
        clr = 1'b1;
        cyc(1, 100);
        chk("abort_v",    v0, 0);
        chk("abort_hold", $signed(o0), 18);
        cyc(1, 1); cyc(1, 2);
        chk("abort_early", v0, 0);
        cyc(1, 3);
        chk("abort_v2",   v0, 1);
        chk("abort_out",  $signed(o0), 6);

        // reset mid-window
        dec_len = 4'd4;
        cyc(1, 2); cyc(1, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_out",   $signed(o0), 0);
        chk("rst_sh2",   $signed(o2), 0);
        chk("rst_valid", v0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1, 2); cyc(1, 2); cyc(1, 2);
        chk("rst_early", v0, 0);
        cyc(1, 2);
        chk("rst_v",     v0, 1);
        chk("rst_fresh", $signed(o0), 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_integrate_dump.md
# ex_integrate_dump

Parametrised signed integrate-and-dump decimator. It is the next generation of the team's single-sample `ce`/`data_valid` example block, and adds configurable width, run-time decimation length, output scaling with rounding, and saturation with a sticky flag. It sits between a sample source strobed by `ce` and any downstream consumer that takes one averaged/decimated sample per window.

## Interface
- `DATA_WIDTH`, default 32: input and output sample width, two's complement.
- `DEC_MAX`, default 16: maximum decimation length, must be ≥ 2.
- `OUT_SHIFT`, default 4: arithmetic right shift applied to the window sum, 0..ACC_W-1.
- Derived, not overridable:
  - `CNT_W` = $clog2(DEC_MAX+1).
  - `ACC_W` = DATA_WIDTH + $clog2(DEC_MAX).

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `clr`  in  1  synchronous window abort and sticky-flag clear, active-high.
- `ce`  in  1  input sample strobe; `data_in` is valid when high.
- `data_in`  in  DATA_WIDTH  signed input sample.
- `dec_len`  in  CNT_W  samples per window (run-time).
- `data_valid`  out  1  one-cycle pulse, `data_out` updated.
- `data_out`  out  DATA_WIDTH  signed decimated result (registered).
- `sat_flag`  out  1  sticky: some output was saturated since reset/`clr`.

## Operation
- State: accumulator `acc` (signed ACC_W), sample counter `cnt` (CNT_W), window length `len_q` (CNT_W).
- Window length handling:
  - `len_q` = `dec_len` clamped to [1, DEC_MAX] (0 → 1, >DEC_MAX → DEC_MAX).
  - Loaded at reset release (from `dec_len`), on `clr`, and at each window close.
  - A `dec_len` change mid-window affects only the next window.
- On `ce`, sign-extend `data_in` to ACC_W.
  - If `cnt` < `len_q`-1: `acc` += sample, `cnt` += 1.
  - If `cnt` == `len_q`-1 (last sample), dump `sum = acc + sample`, then `acc` ← 0 and `cnt` ← 0.
- Dump arithmetic, on sum (ACC_W+1 bits internally):
  - OUT_SHIFT > 0: `r = (sum + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT` (round half toward +inf).
  - OUT_SHIFT = 0: `r = sum`.
  - If r > 2^(DATA_WIDTH-1)-1 or r < -2^(DATA_WIDTH-1): clamp to that bound and set `sat_flag`.
  - `data_out` ← result, `data_valid` ← 1 for exactly one cycle.
- Without `ce`: `acc`/`cnt` hold; `data_valid` = 0; `data_out` holds its last value.
- `clr` (priority over `ce`, same cycle):
  - `acc` ← 0, `cnt` ← 0, `len_q` reloaded, `sat_flag` ← 0, `data_valid` ← 0.
  - The `ce` sample in that cycle is discarded; `data_out` holds.
- Accumulator cannot overflow: ACC_W bits hold DEC_MAX full-scale samples.

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `sat_flag` = 0, `acc` = 0, `cnt` = 0.
- Reset mid-window drops partial sums; the first window after release starts fresh.
- Latency: `data_valid` is high on the cycle after the edge that sampled the last `ce` of the window.
- Back-to-back `ce` is supported at full rate.
  - With `len_q` = 1, every `ce` produces a `data_valid` one cycle later (throughput 1/clk).
  - The sample following a dump cycle is the first sample of the new window; no samples are lost.
- `sat_flag` rises in the same cycle as the saturating `data_valid` pulse.
- `ce` gaps of any length inside a window do not change the result.

## Test plan
- Basic sum: OUT_SHIFT=0, `dec_len`=4, `ce` on 4 consecutive cycles with `data_in` 1,2,3,4 -> `data_valid` pulses once, one cycle after the 4th `ce`, with `data_out`=10; `sat_flag`=0.
- Rounding: OUT_SHIFT=2, `dec_len`=4.
  - Inputs 1,1,1,1 -> `data_out`=1.
  - Inputs -1,-1,0,0 -> `data_out`=0 (−2+2=0).
  - Inputs -3,0,0,0 -> `data_out`=-1.
- Saturation: DATA_WIDTH=8, OUT_SHIFT=0, `dec_len`=4.
  - Inputs 127×4 -> `data_out`=127, `sat_flag`=1.
  - Inputs -128×4 -> `data_out`=-128.
  - `clr` pulse -> `sat_flag`=0.
- Length edges: `dec_len`=0 and `dec_len`=1 -> every `ce` yields `data_valid` with `data_out` = scaled sample. `dec_len`=DEC_MAX+5 -> window of DEC_MAX samples. `dec_len` changed 4→2 after the 2nd sample -> the current window closes after 4 samples, the next after 2.
- Gaps and abort:
  - `dec_len`=3, inputs 5,6,7 with 0–3 idle cycles between `ce` -> `data_out`=18 (OUT_SHIFT=0).
  - `clr` asserted with `ce` after 2 samples -> no pulse, that sample is discarded, and the next 3 samples form a clean window.
- Reset mid-window: `rst` low after 2 of 4 samples -> all outputs return to 0 immediately. After release, 4 new samples of value 2 -> `data_out`=8 (OUT_SHIFT=0).
